// File: rtl/johnson_decoder.sv
// Johnson code decoder and checker.
// Samples a WIDTH-bit Johnson code on code_valid, decodes it to a binary index
// and a one-hot vector, flags illegal patterns and out-of-order successions,
// tracks lock through a three-state machine and counts errors (saturating).
// Optional build macro: JOHNSON_DECODER_HOLD_EN -- a legal code equal to the
// previous one is treated as a hold (valid, no error, state unchanged) so a
// source clocked slower than clk can be monitored.
module johnson_decoder #(
  parameter  int WIDTH    = 4,
  parameter  int LOCK_CNT = 4,
  localparam int N        = 2 * WIDTH,
  localparam int IW       = $clog2(2 * WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] code_in,
  input  logic             code_valid,
  output logic [IW-1:0]    index,
  output logic [N-1:0]     onehot,
  output logic             index_valid,
  output logic             illegal,
  output logic             seq_err,
  output logic             locked,
  output logic [7:0]       err_count
);

  localparam int unsigned WU = WIDTH;
  localparam int unsigned NU = N;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    TRACKING = 2'd1,
    LOCKED   = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [IW-1:0]  ref_q, ref_d;
  logic [7:0]     good_q, good_d;

  logic [IW-1:0]  k;
  logic           legal;
  logic           hold;
  logic [IW-1:0]  expected;
  logic [IW-1:0]  index_d;
  logic [N-1:0]   onehot_d;
  logic           iv_d, il_d, se_d;
  logic [7:0]     err_d;
  logic [7:0]     err_inc;

  int unsigned    pop;
  int unsigned    kk;

  // Decode: popcount gives the position, then the code must match the
  // canonical pattern for that position to be legal.
  always_comb begin
    pop = 0;
    for (int unsigned i = 0; i < WU; i++) begin
      pop = pop + {31'd0, code_in[i]};
    end
    if (code_in == '0 || code_in[0]) begin
      kk = pop;
    end else begin
      kk = NU - pop;
    end
    legal = 1'b1;
    for (int unsigned i = 0; i < WU; i++) begin
      if (((kk <= WU) ? (i < kk) : (i >= kk - WU)) != code_in[i]) begin
        legal = 1'b0;
      end
    end
    k = IW'(kk);
  end

  // Expected successor of the reference and the optional hold detection.
  always_comb begin
    expected = (ref_q == IW'(N - 1)) ? '0 : ref_q + IW'(1);
    err_inc  = (err_count == 8'hFF) ? err_count : err_count + 8'd1;
`ifdef JOHNSON_DECODER_HOLD_EN
    hold = (k == ref_q);
`else
    hold = 1'b0;
`endif
  end

  // Next-state and next-output logic; the reference exists whenever the
  // machine is out of UNLOCKED, so no separate reference-valid flag is kept.
  always_comb begin
    state_d  = state_q;
    good_d   = good_q;
    ref_d    = ref_q;
    index_d  = index;
    onehot_d = '0;
    iv_d     = 1'b0;
    il_d     = 1'b0;
    se_d     = 1'b0;
    err_d    = err_count;
    if (code_valid) begin
      if (!legal) begin
        il_d    = 1'b1;
        state_d = UNLOCKED;
        good_d  = '0;
        ref_d   = '0;
        err_d   = err_inc;
      end else begin
        iv_d        = 1'b1;
        index_d     = k;
        onehot_d[k] = 1'b1;
        ref_d       = k;
        unique case (state_q)
          UNLOCKED: begin
            state_d = TRACKING;
            good_d  = '0;
          end
          TRACKING, LOCKED: begin
            if (hold) begin
              state_d = state_q;
            end else if (k == expected) begin
              if (state_q == TRACKING) begin
                good_d = good_q + 8'd1;
                if (good_q + 8'd1 == 8'(LOCK_CNT)) begin
                  state_d = LOCKED;
                end
              end
            end else begin
              se_d    = 1'b1;
              state_d = TRACKING;
              good_d  = '0;
              err_d   = err_inc;
            end
          end
          default: begin
            state_d = UNLOCKED;
            good_d  = '0;
          end
        endcase
      end
    end
  end

  // State register: lock state, success counter and reference position.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= UNLOCKED;
      good_q  <= '0;
      ref_q   <= '0;
    end else begin
      state_q <= state_d;
      good_q  <= good_d;
      ref_q   <= ref_d;
    end
  end

  // Output registers: all outputs change only on a sampling edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      index       <= '0;
      onehot      <= '0;
      index_valid <= 1'b0;
      illegal     <= 1'b0;
      seq_err     <= 1'b0;
      locked      <= 1'b0;
      err_count   <= '0;
    end else begin
      index       <= index_d;
      onehot      <= onehot_d;
      index_valid <= iv_d;
      illegal     <= il_d;
      seq_err     <= se_d;
      locked      <= (state_d == LOCKED);
      err_count   <= err_d;
    end
  end

endmodule

// File: tb/tb_johnson_decoder.sv
// Scoreboard bench for johnson_decoder: stimulus pushes expected responses
// from a table-driven reference model, a monitor pops and compares them.
module tb_johnson_decoder;

  localparam int W  = 4;
  localparam int LC = 4;
  localparam int N  = 2 * W;
  localparam int IW = $clog2(N);
`ifdef JOHNSON_DECODER_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [W-1:0]  code_in = '0;
  logic          code_valid = 1'b0;
  logic [IW-1:0] index;
  logic [N-1:0]  onehot;
  logic          index_valid, illegal, seq_err, locked;
  logic [7:0]    err_count;

  johnson_decoder #(.WIDTH(W), .LOCK_CNT(LC)) dut (
    .clk(clk), .reset(reset), .code_in(code_in), .code_valid(code_valid),
    .index(index), .onehot(onehot), .index_valid(index_valid),
    .illegal(illegal), .seq_err(seq_err), .locked(locked),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         iv, il, se;
    int           idx;
    logic [N-1:0] oh;
    logic         lk;
    int           err;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] jseq[N];
  int           n_checks = 0;
  int           n_fail   = 0;

  // reference model state
  bit m_has_ref;
  int m_ref, m_good, m_err, m_idx;
  bit m_locked;

  task automatic chk(input string nm, input longint act, input longint req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_has_ref = 0; m_ref = 0; m_good = 0; m_err = 0; m_idx = 0; m_locked = 0;
  endtask

  task automatic model_step(input logic [W-1:0] c);
    exp_t e;
    int pos = -1;
    for (int i = 0; i < N; i++) if (jseq[i] == c) pos = i;
    e.iv = 0; e.il = 0; e.se = 0; e.oh = '0;
    if (pos < 0) begin
      e.il = 1;
      m_has_ref = 0; m_good = 0; m_locked = 0;
      m_err = (m_err < 255) ? m_err + 1 : 255;
    end else begin
      e.iv = 1;
      e.oh[pos] = 1'b1;
      m_idx = pos;
      if (!m_has_ref) begin
        m_good = 0;
      end else if (HOLD && pos == m_ref) begin
        // hold: nothing changes
      end else if (pos == (m_ref + 1) % N) begin
        if (!m_locked) begin
          m_good++;
          if (m_good == LC) m_locked = 1;
        end
      end else begin
        e.se = 1;
        m_good = 0; m_locked = 0;
        m_err = (m_err < 255) ? m_err + 1 : 255;
      end
      m_has_ref = 1;
      m_ref = pos;
    end
    e.idx = m_idx; e.lk = m_locked; e.err = m_err;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic v, input logic [W-1:0] c);
    @(negedge clk);
    code_in = c;
    code_valid = v;
    if (v && reset) model_step(c);
  endtask

  // Monitor: compares every presented output against the scoreboard and
  // checks that idle cycles hold the registered state.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        if (exp_q.size() > 0 || index_valid || illegal || seq_err) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_output", 1, 0);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("index_valid", index_valid, e.iv);
            chk("illegal", illegal, e.il);
            chk("seq_err", seq_err, e.se);
            chk("index", index, e.idx);
            chk("onehot", onehot, e.oh);
            chk("locked", locked, e.lk);
            chk("err_count", err_count, e.err);
          end
        end else begin
          chk("idle_onehot", onehot, 0);
          chk("idle_index", index, m_idx);
          chk("idle_locked", locked, m_locked);
          chk("idle_err_count", err_count, m_err);
        end
      end
    end
  end

  // Stimulus
  initial begin
    logic [W-1:0] q;
    logic [W-1:0] c;
    q = '0;
    for (int i = 0; i < N; i++) begin
      jseq[i] = q;
      q = {q[W-2:0], ~q[W-1]};
    end
    model_reset();

    // reset held with toggling valid codes
    code_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      code_in = jseq[i];
      #1;
      chk("rst_index", index, 0);
      chk("rst_onehot", onehot, 0);
      chk("rst_pulses", {index_valid, illegal, seq_err}, 0);
      chk("rst_locked", locked, 0);
      chk("rst_err_count", err_count, 0);
    end
    @(negedge clk);
    code_valid = 1'b0;
    reset = 1'b1;

    // full sequence with wrap, then illegal, then directed error cases
    for (int i = 0; i <= N; i++) drive(1, jseq[i % N]);
    drive(1, 4'b0101);
    drive(1, 4'b0011);
    drive(1, 4'b0001);
    drive(1, 4'b0011);
    drive(1, 4'b1100);
    drive(1, 4'b1000);
    drive(1, 4'b0011);
    drive(1, 4'b0011);
    drive(0, 4'b0000);

    // randomized mix of successors, random legal codes, arbitrary codes, idles
    for (int i = 0; i < 400; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 55)
        c = m_has_ref ? jseq[(m_ref + 1) % N] : jseq[$urandom_range(0, N - 1)];
      else if (r < 70)
        c = jseq[$urandom_range(0, N - 1)];
      else
        c = W'($urandom_range(0, (1 << W) - 1));
      drive(($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0, c);
    end

    // saturate the error counter
    for (int i = 0; i < 300; i++) drive(1, (i % 2 == 0) ? 4'b0101 : 4'b1010);
    drive(0, 4'b0000);
    @(posedge clk); #2;
    chk("err_saturated", err_count, 255);

    // lock again, then assert reset mid-cycle
    for (int i = 0; i < 6; i++) drive(1, jseq[i]);
    drive(0, 4'b0000);
    @(posedge clk); #2;
    chk("locked_before_reset", locked, 1);
    #1;
    reset = 1'b0;
    #1;
    chk("async_err_count", err_count, 0);
    chk("async_locked", locked, 0);
    chk("async_index", index, 0);
    chk("async_onehot", onehot, 0);
    model_reset();
    exp_q.delete();
    @(negedge clk);
    code_valid = 1'b0;
    reset = 1'b1;
    drive(1, 4'b0011);
    drive(1, 4'b0111);
    for (int i = 0; i < 3; i++) drive(0, 4'b0000);
    @(posedge clk); #2;
    chk("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
